odejmowanie_seq: RTL and testbench
==================================

ODEJMOWANIE_SEQ -- requirements
Module: odejmowanie_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter CHUNK, default 8, bits processed per clock; WIDTH SHALL be an integer multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_start  input  1  request a new subtraction; sampled on rising edge.
REQ-006 i_argA  input  WIDTH  minuend, unsigned.
REQ-007 i_argB  input  WIDTH  subtrahend, unsigned.
REQ-008 o_busy  output  1  high while a subtraction is in progress.
REQ-009 o_done  output  1  one-cycle completion strobe.
REQ-010 o_result  output  WIDTH  difference i_argA - i_argB, modulo 2^WIDTH.
REQ-011 o_borrow  output  1  high when i_argA < i_argB, unsigned.
REQ-012 o_overflow  output  1  signed overflow flag; present only with ODEJMOWANIE_OVERFLOW_EN.

Function
REQ-013 FSM states SHALL be IDLE, CALC and DONE.
REQ-014 IDLE: i_start=1 latches i_argA and i_argB into internal registers, clears the chunk counter and internal borrow, and moves to CALC.
REQ-015 CALC: each cycle SHALL compute chunk k as {b, d} = A[k] - B[k] - borrow, store d in the accumulator and b as the new borrow, starting at the LSB chunk (k=0).
REQ-016 The chunk counter SHALL increment by one each CALC cycle; after chunk N-1 the FSM moves to DONE.
REQ-017 On the transition to DONE, o_result SHALL load the accumulator and o_borrow SHALL load the final borrow.
REQ-018 o_done SHALL be high for exactly the one cycle the FSM is in DONE, first visible after rising edge N counted from the edge that sampled i_start (N=4 with defaults).
REQ-019 o_busy SHALL be high exactly while in CALC.
REQ-020 i_start while in CALC SHALL be ignored; the latched operands SHALL not change.
REQ-021 DONE SHALL go to IDLE on the next edge, or directly to CALC with new operands latched if i_start=1 in that cycle (back-to-back).
REQ-022 o_result and o_borrow SHALL hold their values from completion until the next completion; input changes outside the latch edge SHALL have no effect.
REQ-023 Operand changes on i_argA or i_argB during CALC SHALL not affect the result.

Reset
REQ-024 i_rst=1 at a rising edge SHALL force IDLE, counter 0 and internal borrow 0, and set o_busy, o_done, o_result, o_borrow and o_overflow to 0.
REQ-025 Reset asserted mid-CALC SHALL abort the operation with no o_done pulse; reset SHALL take priority over i_start.

Configuration
REQ-026 Macro ODEJMOWANIE_OVERFLOW_EN defined: port o_overflow SHALL exist, loaded on completion with (A[MSB] != B[MSB]) && (result[MSB] != A[MSB]) using the latched operands.
REQ-027 Macro ODEJMOWANIE_OVERFLOW_EN undefined: port o_overflow and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-028 A=10, B=3, start pulse -> o_busy high for 4 cycles, then o_done pulse, o_result=7, o_borrow=0.
REQ-029 A=3, B=10 -> o_result=0xFFFFFFF9, o_borrow=1.
REQ-030 A=0x00000100, B=0x00000001 -> o_result=0x000000FF, o_borrow=0 (borrow ripples across a chunk boundary).
REQ-031 A=0x80000000, B=1, macro defined -> o_result=0x7FFFFFFF, o_overflow=1, o_borrow=0; A=5, B=3 -> o_overflow=0.
REQ-032 Start A=9, B=4; i_start pulse with A=1, B=1 during CALC -> o_result=5; reset on CALC cycle 2 -> no o_done, all outputs 0 on the next cycle.
REQ-033 i_start held during DONE with A=20, B=5 -> second o_done 5 cycles after the first, o_result=15; compare every result against a behavioural A-B model over at least 100 $urandom pairs.

Source files
------------

// File: rtl/odejmowanie_seq.sv
// Chunk-serial unsigned subtractor: CHUNK bits per clock, LSB chunk first, borrow rippled between cycles.
// Optional signed-overflow output enabled by defining ODEJMOWANIE_OVERFLOW_EN.
module odejmowanie_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_argA,
    input  logic [WIDTH-1:0] i_argB,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_borrow
`ifdef ODEJMOWANIE_OVERFLOW_EN
   ,output logic             o_overflow
`endif
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    if ((WIDTH % CHUNK) != 0 || CHUNK < 1) begin : g_bad_params
        $error("odejmowanie_seq: WIDTH must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               borrow;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   acc_next;
    logic [CHUNK:0]     chunk_diff;
    logic               last_chunk;

    // One extra bit on the chunk difference carries the borrow out.
    always_comb begin
        chunk_diff = {1'b0, a_reg[int'(cnt)*CHUNK +: CHUNK]}
                   - {1'b0, b_reg[int'(cnt)*CHUNK +: CHUNK]}
                   - {{CHUNK{1'b0}}, borrow};
    end

    always_comb begin
        acc_next = acc;
        acc_next[int'(cnt)*CHUNK +: CHUNK] = chunk_diff[CHUNK-1:0];
    end

    assign last_chunk = (cnt == CNT_W'(N - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            borrow   <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_result <= '0;
            o_borrow <= 1'b0;
`ifdef ODEJMOWANIE_OVERFLOW_EN
            o_overflow <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        a_reg  <= i_argA;
                        b_reg  <= i_argB;
                        cnt    <= '0;
                        borrow <= 1'b0;
                        o_busy <= 1'b1;
                        state  <= CALC;
                    end else begin
                        state  <= IDLE;
                    end
                end
                CALC: begin
                    borrow <= chunk_diff[CHUNK];
                    acc    <= acc_next;
                    if (last_chunk) begin
                        cnt      <= '0;
                        o_busy   <= 1'b0;
                        o_done   <= 1'b1;
                        o_result <= acc_next;
                        o_borrow <= chunk_diff[CHUNK];
`ifdef ODEJMOWANIE_OVERFLOW_EN
                        o_overflow <= (a_reg[WIDTH-1] != b_reg[WIDTH-1])
                                   && (acc_next[WIDTH-1] != a_reg[WIDTH-1]);
`endif
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    o_busy <= 1'b0;
                    o_done <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_odejmowanie_seq.sv
// Randomized self-checking bench for odejmowanie_seq against a plain-arithmetic subtraction model.
// Overflow checks are included when ODEJMOWANIE_OVERFLOW_EN is defined.
module tb_odejmowanie_seq;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int N     = WIDTH / CHUNK;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] arg_a;
    logic [WIDTH-1:0] arg_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             borrow;
`ifdef ODEJMOWANIE_OVERFLOW_EN
    logic             overflow;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [WIDTH-1:0] exp_result;
    logic             exp_borrow;
    logic             exp_overflow;

    odejmowanie_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_argA     (arg_a),
        .i_argB     (arg_b),
        .o_busy     (busy),
        .o_done     (done),
        .o_result   (result),
        .o_borrow   (borrow)
`ifdef ODEJMOWANIE_OVERFLOW_EN
       ,.o_overflow (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Reference: full-precision subtraction; borrow is the sign of the widened difference.
    task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] wide;
        wide         = {1'b0, a} - {1'b0, b};
        exp_result   = wide[WIDTH-1:0];
        exp_borrow   = (a < b);
        exp_overflow = (a[WIDTH-1] != b[WIDTH-1]) && (exp_result[WIDTH-1] != a[WIDTH-1]);
    endtask

    // noise: 0 quiet, 1 random operands/start during CALC, 2 one start pulse with A=1,B=1.
    // Returns at the negedge where o_done is observed high.
    task automatic do_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input int noise);
        int waited;
        int busy_cnt;
        model(a, b);
        @(negedge clk);
        arg_a = a;
        arg_b = b;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        waited   = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && waited < 50) begin
            if (busy === 1'b1) busy_cnt++;
            if (noise == 1) begin
                arg_a = $urandom;
                arg_b = $urandom;
                start = 1'($urandom_range(0, 1));
            end else if (noise == 2) begin
                start = (waited == 0);
                arg_a = 1;
                arg_b = 1;
            end
            @(negedge clk);
            waited++;
        end
        start = 1'b0;
        check({tag, ".latency"}, 64'(waited), 64'(N));
        check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(N));
        check({tag, ".result"}, 64'(result), 64'(exp_result));
        check({tag, ".borrow"}, 64'(borrow), 64'(exp_borrow));
`ifdef ODEJMOWANIE_OVERFLOW_EN
        check({tag, ".overflow"}, 64'(overflow), 64'(exp_overflow));
`endif
    endtask

    task automatic check_hold(input string tag);
        arg_a = $urandom;
        arg_b = $urandom;
        @(negedge clk);
        check({tag, ".done_low"}, 64'(done), 64'd0);
        check({tag, ".hold_result"}, 64'(result), 64'(exp_result));
        check({tag, ".hold_borrow"}, 64'(borrow), 64'(exp_borrow));
    endtask

    initial begin
        int cyc;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;

        rst   = 1'b1;
        start = 1'b0;
        arg_a = '0;
        arg_b = '0;
        repeat (3) @(negedge clk);
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.result", 64'(result), 64'd0);
        check("reset.borrow", 64'(borrow), 64'd0);
        rst = 1'b0;

        do_op("a10_b3", 32'd10, 32'd3, 0);
        check("a10_b3.literal", 64'(result), 64'd7);
        check_hold("a10_b3");
        do_op("a3_b10", 32'd3, 32'd10, 0);
        check("a3_b10.literal", 64'(result), 64'hFFFF_FFF9);
        do_op("ripple", 32'h0000_0100, 32'h0000_0001, 0);
        check("ripple.literal", 64'(result), 64'h0000_00FF);
        do_op("minneg", 32'h8000_0000, 32'd1, 0);
        check("minneg.literal", 64'(result), 64'h7FFF_FFFF);
        do_op("a5_b3", 32'd5, 32'd3, 0);
        do_op("ignore_start", 32'd9, 32'd4, 2);
        check("ignore_start.literal", 64'(result), 64'd5);

        // Back-to-back: start held in DONE launches the next operation directly.
        do_op("b2b_first", 32'd7, 32'd2, 0);
        arg_a = 32'd20;
        arg_b = 32'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (done !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b.spacing", 64'(cyc), 64'(N + 1));
        check("b2b.result", 64'(result), 64'd15);
        check("b2b.borrow", 64'(borrow), 64'd0);
        @(negedge clk);

        // Abort mid-CALC: reset sampled on the second CALC cycle, with start also high.
        arg_a = 32'd9;
        arg_b = 32'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check("abort.busy", 64'(busy), 64'd0);
        check("abort.done", 64'(done), 64'd0);
        check("abort.result", 64'(result), 64'd0);
        check("abort.borrow", 64'(borrow), 64'd0);
`ifdef ODEJMOWANIE_OVERFLOW_EN
        check("abort.overflow", 64'(overflow), 64'd0);
`endif
        @(negedge clk);
        check("abort.rst_over_start", 64'(busy), 64'd0);
        rst   = 1'b0;
        start = 1'b0;
        cyc   = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) cyc++;
        end
        check("abort.no_done", 64'(cyc), 64'd0);

        for (int i = 0; i < 120; i++) begin
            case ($urandom_range(0, 5))
                0:       begin a = '0;          b = $urandom; end
                1:       begin a = $urandom;    b = '1;       end
                2:       begin a = $urandom;    b = a;        end
                default: begin a = $urandom;    b = $urandom; end
            endcase
            do_op("rand", a, b, 1);
            if (i % 8 == 0) check_hold("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
